// File: rtl/palette_lookup_arbiter.sv
// Round-robin arbiter that shares one fixed 16-entry palette LUT among N_REQ requesters.
// Each granted lookup returns a registered, requester-tagged and optionally dimmed RGB result one cycle later.
module palette_lookup_arbiter #(
  parameter int         N_REQ      = 4,
  parameter int         IDW        = 2,
  parameter logic [3:0] TRANSP_IDX = 4'h0
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] req_index,
  input  logic [1:0]         dim,
  output logic [N_REQ-1:0]   gnt,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic               rsp_transparent,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue
);

  function automatic logic [11:0] palette(input logic [3:0] idx);
    case (idx)
      4'h0: palette = 12'h6BE;
      4'h1: palette = 12'h000;
      4'h2: palette = 12'hC65;
      4'h3: palette = 12'h39D;
      4'h4: palette = 12'hEA9;
      4'h5: palette = 12'h8CE;
      4'h6: palette = 12'h721;
      4'h7: palette = 12'hDDE;
      4'h8: palette = 12'h246;
      4'h9: palette = 12'h5AD;
      4'hA: palette = 12'hD87;
      4'hB: palette = 12'h78A;
      4'hC: palette = 12'h29D;
      4'hD: palette = 12'h113;
      4'hE: palette = 12'h27B;
      default: palette = 12'h943;
    endcase
  endfunction

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           found;
  logic [IDW-1:0] win;
  logic [3:0]     win_idx;
  logic [11:0]    lut_rgb;
  logic [11:0]    dim_rgb;

  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic           rsp_transp_q;
  logic [11:0]    rgb_q;

  always_comb begin
    int cand;
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    cand  = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % N_REQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = IDW'(cand);
      end
    end
  end

  // gnt is combinational from req, so it must be gated explicitly while reset is held.
  always_comb begin
    gnt = '0;
    if (found && Reset_n) gnt[win] = 1'b1;
  end

  assign win_idx = req_index[4*win +: 4];
  assign lut_rgb = palette(win_idx);
  // Channels are shifted independently so no bits leak from one colour into the next.
  assign dim_rgb = {lut_rgb[11:8] >> dim, lut_rgb[7:4] >> dim, lut_rgb[3:0] >> dim};

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (found) rr_ptr_d = (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!Reset_n) begin
      rr_ptr_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_transp_q <= 1'b0;
      rgb_q        <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= found;
      if (found) begin
        rsp_id_q     <= win;
        rsp_transp_q <= (win_idx == TRANSP_IDX);
        rgb_q        <= dim_rgb;
      end
    end
  end

  assign rsp_valid       = rsp_valid_q;
  assign rsp_id          = rsp_id_q;
  assign rsp_transparent = rsp_transp_q;
  assign red             = rgb_q[11:8];
  assign green           = rgb_q[7:4];
  assign blue            = rgb_q[3:0];

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Bench for palette_lookup_arbiter: table-driven grant vectors, a response scoreboard,
// reset corner cases and a randomized fairness run against a small round-robin model.
module tb_palette_lookup_arbiter;

  localparam int N = 4;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [3:0]  req;
  logic [15:0] req_index;
  logic [1:0]  dim;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic        rsp_transparent;
  logic [3:0]  red, green, blue;

  palette_lookup_arbiter #(.N_REQ(4), .IDW(2), .TRANSP_IDX(4'h0)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .req_index(req_index), .dim(dim),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_transparent(rsp_transparent),
    .red(red), .green(green), .blue(blue)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        valid;
    logic [1:0]  id;
    logic        transp;
    logic [11:0] rgb;
  } rsp_t;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] idx;
    logic [1:0]  dim;
    logic [3:0]  exp_gnt;
  } vec_t;

  logic [11:0] lut [16] = '{12'h6BE, 12'h000, 12'hC65, 12'h39D, 12'hEA9, 12'h8CE, 12'h721, 12'hDDE,
                            12'h246, 12'h5AD, 12'hD87, 12'h78A, 12'h29D, 12'h113, 12'h27B, 12'h943};

  rsp_t sb[$];
  rsp_t last_exp;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Called just after a falling edge: drive, check gnt, predict, then check the response next cycle.
  task automatic step(input logic [3:0] r, input logic [15:0] ix, input logic [1:0] d,
                      input logic [3:0] eg);
    rsp_t        e;
    rsp_t        got;
    logic [3:0]  nib;
    logic [11:0] c;
    req = r; req_index = ix; dim = d;
    #1;
    check("gnt", {28'd0, gnt}, {28'd0, eg});
    e = last_exp;
    e.valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (eg[i]) begin
        nib      = ix[4*i +: 4];
        c        = lut[nib];
        e.valid  = 1'b1;
        e.id     = 2'(i);
        e.transp = (nib == 4'h0);
        e.rgb    = {c[11:8] >> d, c[7:4] >> d, c[3:0] >> d};
        last_exp = e;
      end
    end
    sb.push_back(e);
    @(negedge Clk);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check("rsp_valid", {31'd0, rsp_valid}, {31'd0, got.valid});
      check("rsp_id", {30'd0, rsp_id}, {30'd0, got.id});
      check("rsp_transparent", {31'd0, rsp_transparent}, {31'd0, got.transp});
      check("rgb", {20'd0, red, green, blue}, {20'd0, got.rgb});
    end
  endtask

  task automatic clear_model();
    last_exp = '{valid: 1'b0, id: 2'd0, transp: 1'b0, rgb: 12'd0};
  endtask

  vec_t vecs[$];

  initial begin
    logic [3:0] cur;
    logic [3:0] eg;
    int         mptr;
    int         wait_cnt [N];

    // Round-robin continuation (after the post-reset grant to 0), sparse/wrap, dim, misc.
    vecs = '{
      '{4'hF, 16'h0172, 2'd0, 4'b0010},
      '{4'hF, 16'h0172, 2'd0, 4'b0100},
      '{4'hF, 16'h0172, 2'd0, 4'b1000},
      '{4'hF, 16'h0172, 2'd0, 4'b0001},
      '{4'h4, 16'h0172, 2'd0, 4'b0100},
      '{4'h5, 16'h0172, 2'd0, 4'b0001},
      '{4'h5, 16'h0172, 2'd0, 4'b0100},
      '{4'h0, 16'h0172, 2'd0, 4'b0000},
      '{4'hF, 16'h0172, 2'd0, 4'b1000},
      '{4'h1, 16'h0002, 2'd0, 4'b0001},
      '{4'h1, 16'h0002, 2'd1, 4'b0001},
      '{4'h1, 16'h0002, 2'd2, 4'b0001},
      '{4'h1, 16'h0002, 2'd3, 4'b0001},
      '{4'hF, 16'hA9B8, 2'd2, 4'b0010},
      '{4'h2, 16'hA9B8, 2'd0, 4'b0010},
      '{4'h8, 16'hA9B8, 2'd1, 4'b1000}
    };

    // Reset held with all requests pending.
    clear_model();
    Reset_n = 1'b0; req = 4'hF; req_index = 16'h0172; dim = 2'd0;
    repeat (2) @(negedge Clk);
    check("reset_gnt", {28'd0, gnt}, 32'd0);
    check("reset_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rgb", {20'd0, red, green, blue}, 32'd0);
    Reset_n = 1'b1;
    step(4'hF, 16'h0172, 2'd0, 4'b0001);

    foreach (vecs[v]) step(vecs[v].req, vecs[v].idx, vecs[v].dim, vecs[v].exp_gnt);

    // Asynchronous reset between edges while a result is valid.
    step(4'h2, 16'h0050, 2'd0, 4'b0010);
    #2;
    Reset_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_id", {30'd0, rsp_id}, 32'd0);
    check("midrst_rgb", {20'd0, red, green, blue}, 32'd0);
    check("midrst_gnt", {28'd0, gnt}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    clear_model();
    step(4'hF, 16'h0172, 2'd0, 4'b0001);

    // Randomized fairness: req[0] always set, others only drop after being granted.
    mptr = 1;
    cur  = 4'b0001;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int t = 0; t < 1000; t++) begin
      eg = '0;
      for (int k = 0; k < N; k++) begin
        if (eg == 0 && cur[(mptr + k) % N]) eg[(mptr + k) % N] = 1'b1;
      end
      step(cur, 16'($urandom), 2'($urandom_range(0, 3)), eg);
      for (int i = 0; i < N; i++) begin
        if (eg[i]) begin
          check("fair_wait", 32'(wait_cnt[i] < N), 32'd1);
          wait_cnt[i] = 0;
          mptr = (i == N - 1) ? 0 : i + 1;
        end else if (cur[i]) begin
          wait_cnt[i]++;
        end
      end
      for (int i = 1; i < N; i++) begin
        if (!cur[i] || eg[i]) cur[i] = 1'($urandom_range(0, 1));
        if (!cur[i]) wait_cnt[i] = 0;
      end
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
